// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the PLL clock/reset supervisor.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } sup_state_e;

  localparam int LOSS_CNT_W = 8;

  // Width of the shared STABLE/HOLD phase counter: wide enough for the longer phase.
  function automatic int phase_cnt_w(input int stable_cycles, input int hold_cycles);
    int m;
    m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: strobes every div+1 cycles while run is high.
// The period register only reloads at a wrap, so a divide change never
// truncates or stretches the period in progress.
module clk_en_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 ce
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] per_q, per_d;

  // Next count/period: idle holds count at zero and tracks div; running wraps at per.
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (!run) begin
      cnt_d = '0;
      per_d = div;
    end else if (cnt_q == per_q) begin
      cnt_d = '0;
      per_d = div;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Phase counter register; cleared by reset so all channels restart aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Period register; reloads from div every idle cycle, so it needs no reset.
  always_ff @(posedge clk) begin
    per_q <= per_d;
  end

  assign ce = run && (cnt_q == '0);

endmodule

// File: rtl/pll_supervisor.sv
// PLL lock supervisor: synchronises and filters the lock flag, holds
// downstream logic in reset for a fixed time after stable lock, then runs
// phase-aligned clock-enable channels. Lock losses in RUN are counted.
module pll_supervisor
  import clk_rst_pkg::*;
#(
  parameter int CHANNELS           = 3,
  parameter int DIV_WIDTH          = 8,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pll_lock_i,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_i,
  output logic                          sys_rst_o,
  output logic                          ready_o,
  output logic [CHANNELS-1:0]           ce_o,
  output logic [LOSS_CNT_W-1:0]         lock_loss_cnt_o
);

  localparam int PH_W = phase_cnt_w(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [PH_W-1:0] STABLE_LAST = PH_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST   = PH_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

  logic [1:0]            sync_q;
  logic                  lock_s;
  sup_state_e            state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  run;

  // Two-flop synchroniser; the only place pll_lock_i is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock_i};
    end
  end

  assign lock_s = sync_q[1];

  // Next-state logic: any lock drop outranks phase completion and clears the count.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    loss_d  = loss_q;
    if (!lock_s) begin
      state_d = WAIT_LOCK;
      phase_d = '0;
      if (state_q == RUN && loss_q != LOSS_MAX) begin
        loss_d = loss_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d = STABLE;
          phase_d = '0;
        end
        STABLE: begin
          if (phase_q == STABLE_LAST) begin
            state_d = HOLD;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        HOLD: begin
          if (phase_q == HOLD_LAST) begin
            state_d = RUN;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        RUN: begin
          phase_d = '0;
        end
        default: begin
          state_d = WAIT_LOCK;
          phase_d = '0;
        end
      endcase
    end
  end

  // State, phase counter and loss counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      phase_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      loss_q  <= loss_d;
    end
  end

  assign run             = (state_q == RUN);
  assign sys_rst_o       = !run;
  assign ready_o         = run;
  assign lock_loss_cnt_o = loss_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clk_en_div #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_div (
      .clk (clk),
      .rst (rst),
      .run (run),
      .div (div_i[k*DIV_WIDTH +: DIV_WIDTH]),
      .ce  (ce_o[k])
    );
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Parametrised clock/reset supervisor placed directly after the Gowin PLL primitive wrapper in the top level. It filters the PLL `lock` flag and holds the system in reset for a fixed time after lock is stable. It then releases reset and generates CHANNELS independent, phase-aligned clock-enable strobes with run-time divide ratios. Any loss of lock returns the system to reset and is counted.

## Interface
Parameters:
- `CHANNELS`, default 3: number of clock-enable outputs.
- `DIV_WIDTH`, default 8: width of each channel divide value.
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronised-lock-high cycles required before the hold phase (≥1).
- `RESET_HOLD_CYCLES`, default 256: cycles `sys_rst_o` stays high after lock is declared stable (≥1).

Ports:
- `clk` in 1: free-running clock; the block runs entirely in this domain.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `pll_lock_i` in 1: PLL lock flag, asynchronous to `clk`.
- `div_i` in CHANNELS*DIV_WIDTH: channel k divide value in bits [k*DIV_WIDTH +: DIV_WIDTH]; strobe period is div+1 cycles.
- `sys_rst_o` out 1: synchronous active-high reset for downstream logic.
- `ready_o` out 1: high while in RUN.
- `ce_o` out CHANNELS: one-cycle clock-enable strobes.
- `lock_loss_cnt_o` out 8: saturating count of lock losses that occurred while in RUN.

## Operation
- `pll_lock_i` passes through a 2-flop synchroniser to produce `lock_s`. Nothing else samples `pll_lock_i` directly.
- State machine:
  - WAIT_LOCK → STABLE when `lock_s`=1.
  - STABLE: counter runs for exactly LOCK_STABLE_CYCLES cycles, then → HOLD.
  - HOLD: counter runs for exactly RESET_HOLD_CYCLES cycles, then → RUN.
  - RUN: stays in RUN.
  - In STABLE, HOLD or RUN, `lock_s`=0 → WAIT_LOCK on the next edge and the counter clears. There is no partial credit for a glitch.
- Output decodes (from registered state only, no combinational path from inputs):
  - `sys_rst_o` = (state != RUN).
  - `ready_o` = (state == RUN).
- `lock_loss_cnt_o` increments only on a RUN→WAIT_LOCK transition caused by `lock_s`=0. It saturates at 255. It is cleared only by `rst`.
- Each channel k has a counter `cnt_k` and a period register `per_k`, both DIV_WIDTH wide.
  - Outside RUN: `cnt_k`=0, and `per_k` loads its `div_i` slice every cycle.
  - In RUN: if `cnt_k`==`per_k`, then `cnt_k`←0 and `per_k`←current `div_i` slice; otherwise `cnt_k`←`cnt_k`+1.
  - `ce_o[k]` = RUN && `cnt_k`==0.
  - div=0 gives `ce_o[k]` constantly high in RUN. The maximum div gives a period of 2^DIV_WIDTH.
  - A `div_i` change takes effect only at the next wrap. There are no truncated or extended periods mid-count.
- Reset: `rst`=1 clears the synchroniser, state (WAIT_LOCK), all counters and `lock_loss_cnt_o`. `rst` takes priority over every transition, including mid-RUN; it does not increment the loss counter.

## Timing
- Reset values: `sys_rst_o`=1, `ready_o`=0, `ce_o`=0, `lock_loss_cnt_o`=0.
- Lock rise:
  - If `pll_lock_i` is first sampled high at edge 0, then `lock_s`=1 after edge 1 and state=STABLE after edge 2.
  - State=HOLD after edge 2+LOCK_STABLE_CYCLES.
  - State=RUN after edge 2+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.
- At RUN entry: `ready_o` rises, `sys_rst_o` falls and every `ce_o[k]` pulses, all in the same cycle. This is the phase-alignment point.
- Lock fall:
  - If `pll_lock_i` is first sampled low at edge t, then after edge t+2 the state is WAIT_LOCK. In that cycle `sys_rst_o`=1, `ready_o`=0 and `ce_o`=0.
  - A strobe may still occur during cycles t and t+1.
- Lock fall coincident with the end of a STABLE or HOLD count: the lock loss wins and the next state is WAIT_LOCK.

## Structure
- Shared package `clk_rst_pkg` holds:
  - the state enum {WAIT_LOCK, STABLE, HOLD, RUN};
  - `LOSS_CNT_W`=8;
  - a function computing the phase-counter width, $clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)+1).
- Sub-module `clk_en_div`: one channel (DIV_WIDTH parameter; inputs `run` and `div`; output `ce`). It is instantiated CHANNELS times in a generate loop. The synchroniser and FSM stay in `pll_supervisor`.

## Test plan
- Reset values:
  - Stimulus: `rst` high for 3 cycles with `pll_lock_i`=1.
  - Required: `sys_rst_o`=1, `ready_o`=0, `ce_o`=0, `lock_loss_cnt_o`=0 throughout; counting restarts from WAIT_LOCK after release.
- Lock-up latency:
  - Stimulus: LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=3; `pll_lock_i` rises, first sampled at edge 0.
  - Required: `ready_o` rises and `sys_rst_o` falls after edge 9, with all `ce_o` pulsing in that cycle.
- Divide ratios:
  - Stimulus: DIV_WIDTH=8; divs 0, 2 and 255 on channels 0, 1 and 2.
  - Required, counting RUN cycles from 0: ch0 high every cycle; ch1 at 0, 3, 6, …; ch2 at 0, 256, 512.
- Divide change mid-period:
  - Stimulus: ch1 div changes 2→4 during RUN cycle 1.
  - Required: ch1 pulses at RUN cycles 0, 3, 8, 13.
- Glitch filter:
  - Stimulus: `pll_lock_i` drops for 1 cycle in the middle of STABLE.
  - Required: return to WAIT_LOCK; the full LOCK_STABLE_CYCLES count restarts; `lock_loss_cnt_o` stays 0.
- Lock loss in RUN:
  - Stimulus: `pll_lock_i` falls, first sampled low at edge t.
  - Required: after edge t+2, `sys_rst_o`=1, `ready_o`=0, `ce_o`=0 and `lock_loss_cnt_o`=1.
  - Stimulus: 300 such losses.
  - Required: `lock_loss_cnt_o` saturates at 255.
